// File: rtl/inst_axi_rd_bridge.sv
// Instruction-cache miss to AXI4 read bridge: one single-beat 32-bit read per
// cache strobe, with kseg0/kseg1 address folding and a sticky bus error flag.
module inst_axi_rd_bridge #(
   parameter int         A_WIDTH = 32,
   parameter logic [3:0] AXI_ID  = 4'd0
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [A_WIDTH-1:0] m_a,
   input  logic               m_strobe,
   output logic [31:0]        m_dout,
   output logic               m_ready,
   output logic [3:0]         arid,
   output logic [A_WIDTH-1:0] araddr,
   output logic [7:0]         arlen,
   output logic [2:0]         arsize,
   output logic [1:0]         arburst,
   output logic               arvalid,
   input  logic               arready,
   input  logic [31:0]        rdata,
   input  logic [1:0]         rresp,
   input  logic               rvalid,
   output logic               rready,
   output logic               bus_err
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ADDR,
      S_DATA,
      S_RESP
   } state_e;

   state_e             state_q, state_d;
   logic [A_WIDTH-1:0] araddr_q, araddr_d;
   logic [31:0]        dout_q, dout_d;
   logic               err_q, err_d;
   logic [A_WIDTH-1:0] xlat_addr;

   // kseg0/kseg1 (top bits 2'b10) map onto the low 512 MB of physical space.
   generate
      if (A_WIDTH >= 32) begin : g_xlat
         always_comb begin
            xlat_addr = m_a;
            if (m_a[31:30] == 2'b10) begin
               xlat_addr[31:29] = 3'b000;
            end
         end
      end else begin : g_no_xlat
         assign xlat_addr = m_a;
      end
   endgenerate

   always_comb begin
      state_d  = state_q;
      araddr_d = araddr_q;
      dout_d   = dout_q;
      err_d    = err_q;
      unique case (state_q)
         S_IDLE: begin
            if (m_strobe) begin
               araddr_d = xlat_addr;
               state_d  = S_ADDR;
            end
         end
         S_ADDR: begin
            if (arready) begin
               state_d = S_DATA;
            end
         end
         S_DATA: begin
            if (rvalid) begin
               dout_d  = rdata;
               err_d   = err_q | (rresp != 2'b00);
               state_d = S_RESP;
            end
         end
         S_RESP: begin
            // The strobe is deliberately ignored here; IDLE re-samples it next edge.
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_IDLE;
         araddr_q <= '0;
         dout_q   <= 32'd0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         araddr_q <= araddr_d;
         dout_q   <= dout_d;
         err_q    <= err_d;
      end
   end

   assign arvalid = (state_q == S_ADDR);
   assign rready  = (state_q == S_DATA);
   assign m_ready = (state_q == S_RESP);
   assign araddr  = araddr_q;
   assign m_dout  = dout_q;
   assign bus_err = err_q;

   assign arid    = AXI_ID;
   assign arlen   = 8'd0;
   assign arsize  = 3'b010;
   assign arburst = 2'b01;

endmodule

// File: tb/tb_inst_axi_rd_bridge.sv
// Randomized bench for inst_axi_rd_bridge: a timestamp model predicts every
// output each cycle from the handshake latency rules and per-transaction delays.
module tb_inst_axi_rd_bridge;

   localparam logic [3:0] ID = 4'hA;

   logic        clk;
   logic        rst;
   logic [31:0] m_a;
   logic        m_strobe;
   logic [31:0] m_dout;
   logic        m_ready;
   logic [3:0]  arid;
   logic [31:0] araddr;
   logic [7:0]  arlen;
   logic [2:0]  arsize;
   logic [1:0]  arburst;
   logic        arvalid;
   logic        arready;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rvalid;
   logic        rready;
   logic        bus_err;

   inst_axi_rd_bridge #(.A_WIDTH(32), .AXI_ID(ID)) dut (
      .clk(clk), .rst(rst), .m_a(m_a), .m_strobe(m_strobe),
      .m_dout(m_dout), .m_ready(m_ready), .arid(arid), .araddr(araddr),
      .arlen(arlen), .arsize(arsize), .arburst(arburst), .arvalid(arvalid),
      .arready(arready), .rdata(rdata), .rresp(rresp), .rvalid(rvalid),
      .rready(rready), .bus_err(bus_err)
   );

   typedef struct {
      int          s;
      int          da;
      int          dr;
      logic [31:0] addr;
      logic [31:0] data;
      logic [1:0]  resp;
   } txn_t;

   txn_t q[$];
   int   cyc = 0;
   int   vec = 0;
   int   miss = 0;
   int   ntx = 0;

   // slave programming for the current transaction
   int          sl_da = 0, sl_dr = 0;
   logic [31:0] sl_data = 32'd0;
   logic [1:0]  sl_resp = 2'b00;
   int          ar_cnt = 0, r_cnt = 0;

   // observations of the most recent transaction, relative to its sample cycle
   int          obs_s, obs_mr, obs_mr_n, obs_ar_n, obs_ar_first;
   logic [31:0] obs_addr, obs_dout;
   logic [7:0]  obs_arlen;
   logic        obs_err;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      vec++;
      if (got !== exp) begin
         miss++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   function automatic logic [31:0] xlat(input logic [31:0] a);
      if (a >= 32'h8000_0000 && a < 32'hC000_0000) return a % 32'h2000_0000;
      return a;
   endfunction

   // Reactive AXI slave: arready on the da-th arvalid cycle, rvalid on the
   // dr-th rready cycle; random junk otherwise, which the bridge must ignore.
   always @(negedge clk) begin
      if (rst) begin
         arready = 1'b0;
         rvalid  = 1'b0;
         rdata   = 32'd0;
         rresp   = 2'b00;
         ar_cnt  = 0;
         r_cnt   = 0;
      end else begin
         if (arvalid) begin
            arready = (ar_cnt == sl_da);
            ar_cnt++;
         end else begin
            arready = 1'($urandom % 2);
            ar_cnt  = 0;
         end
         if (rready) begin
            rvalid = (r_cnt == sl_dr);
            rdata  = rvalid ? sl_data : $urandom;
            rresp  = rvalid ? sl_resp : 2'($urandom);
            r_cnt++;
         end else begin
            rvalid = 1'($urandom % 2);
            rdata  = $urandom;
            rresp  = 2'($urandom);
            r_cnt  = 0;
         end
      end
   end

   // Per-cycle comparison against the timestamp model.
   logic        e_av, e_rr, e_mr, e_err;
   logic [31:0] e_addr, e_dout;
   int          t_s, t_m;
   always @(negedge clk) begin
      if (cyc >= 2) begin
         e_av = 1'b0; e_rr = 1'b0; e_mr = 1'b0; e_err = 1'b0;
         e_addr = 32'd0; e_dout = 32'd0;
         if (!rst) begin
            foreach (q[i]) begin
               t_s = q[i].s;
               t_m = t_s + 3 + q[i].da + q[i].dr;
               if (cyc >= t_s + 1 && cyc <= t_s + 1 + q[i].da) e_av = 1'b1;
               if (cyc >= t_s + 2 + q[i].da && cyc <= t_m - 1) e_rr = 1'b1;
               if (cyc == t_m) e_mr = 1'b1;
               if (cyc >= t_s + 1) e_addr = xlat(q[i].addr);
               if (cyc >= t_m) begin
                  e_dout = q[i].data;
                  if (q[i].resp != 2'b00) e_err = 1'b1;
               end
            end
         end
         chk("arvalid", 32'(arvalid), 32'(e_av));
         chk("rready", 32'(rready), 32'(e_rr));
         chk("m_ready", 32'(m_ready), 32'(e_mr));
         chk("araddr", araddr, e_addr);
         chk("m_dout", m_dout, e_dout);
         chk("bus_err", 32'(bus_err), 32'(e_err));
         chk("ar_const", 32'({arid, arlen, arsize, arburst}), 32'({ID, 8'd0, 3'b010, 2'b01}));
      end
   end

   task automatic chk_zero(input string tag);
      chk({tag, "_arvalid"}, 32'(arvalid), 32'd0);
      chk({tag, "_rready"}, 32'(rready), 32'd0);
      chk({tag, "_m_ready"}, 32'(m_ready), 32'd0);
      chk({tag, "_m_dout"}, m_dout, 32'd0);
      chk({tag, "_araddr"}, araddr, 32'd0);
      chk({tag, "_bus_err"}, 32'(bus_err), 32'd0);
   endtask

   // Entered and left at a negedge where the bridge is idle. abort_at >= 0
   // asserts reset that many cycles after the sample cycle and returns with
   // rst still high; relrst releases it while presenting the new strobe.
   task automatic do_txn(input logic [31:0] addr, input logic [31:0] data,
                         input logic [1:0] resp, input int da, input int dr,
                         input int gap, input bit hold, input int abort_at,
                         input bit relrst);
      int   s, m, rel, g;
      txn_t r;
      g = relrst ? 0 : gap;
      for (int i = 0; i < g; i++) begin
         m_strobe = 1'b0;
         m_a = $urandom;
         @(negedge clk);
      end
      m_strobe = 1'b1;
      m_a = addr;
      sl_da = da; sl_dr = dr; sl_data = data; sl_resp = resp;
      if (relrst) #1 rst = 1'b0;
      s = cyc;
      m = s + 3 + da + dr;
      r.s = s; r.da = da; r.dr = dr; r.addr = addr; r.data = data; r.resp = resp;
      q.push_back(r);
      obs_s = s; obs_mr = -1; obs_mr_n = 0; obs_ar_n = 0; obs_ar_first = -1;
      obs_addr = 32'd0; obs_dout = 32'd0; obs_arlen = 8'hFF; obs_err = 1'b0;
      ntx++;
      $display("txn %0d: cycle %0d addr=%h data=%h resp=%0d ar_wait=%0d r_wait=%0d%s",
               ntx, s, addr, data, resp, da, dr, (abort_at >= 0) ? " (reset mid-flight)" : "");
      while (cyc < m) begin
         @(negedge clk);
         rel = cyc - s;
         if (arvalid) begin
            obs_ar_n++;
            if (obs_ar_first < 0) obs_ar_first = rel;
         end
         if (m_ready) begin
            obs_mr_n++;
            if (obs_mr < 0) begin
               obs_mr = rel;
               obs_dout = m_dout;
            end
         end
         if (rel == 1) begin
            obs_addr = araddr;
            obs_arlen = arlen;
         end
         if (cyc == m) obs_err = bus_err;
         if (rel == abort_at) begin
            #1 rst = 1'b1;
            #1 chk_zero("async_rst");
            q.delete();
            m_strobe = 1'b0;
            @(negedge clk);
            return;
         end
         m_a = $urandom;
         m_strobe = (cyc == m) ? hold : 1'($urandom % 4 != 0);
      end
      @(negedge clk);
   endtask

   int          s1;
   bit          pend_rst;
   logic [31:0] ra, rd;
   logic [1:0]  rr;
   int          rda, rdr, rab;

   initial begin
      rst = 1'b1;
      m_strobe = 1'b0;
      m_a = 32'd0;
      repeat (3) @(negedge clk);
      chk_zero("reset");
      #1 rst = 1'b0;
      @(negedge clk);

      // zero-wait kseg1 boot fetch
      do_txn(32'hBFC0_0000, 32'h3C1D_8000, 2'b00, 0, 0, 0, 1'b0, -1, 1'b0);
      chk("boot_araddr", obs_addr, 32'h1FC0_0000);
      chk("boot_arlen", 32'(obs_arlen), 32'd0);
      chk("boot_arvalid_at", 32'(obs_ar_first), 32'd1);
      chk("boot_ready_at", 32'(obs_mr), 32'd3);
      chk("boot_ready_len", 32'(obs_mr_n), 32'd1);
      chk("boot_dout", obs_dout, 32'h3C1D_8000);

      // kuseg passes through untranslated
      do_txn(32'h0040_0010, 32'h2408_0001, 2'b00, 0, 1, 1, 1'b0, -1, 1'b0);
      chk("kuseg_araddr", obs_addr, 32'h0040_0010);

      // slow slave: arready after 4 waits, rvalid 3 cycles after rready
      do_txn(32'h8000_0180, 32'h0000_0000, 2'b00, 4, 3, 2, 1'b0, -1, 1'b0);
      chk("slow_arvalid_len", 32'(obs_ar_n), 32'd5);
      chk("slow_ready_at", 32'(obs_mr), 32'd10);
      chk("slow_araddr", obs_addr, 32'h0000_0180);

      // strobe held through RESP: one idle cycle, then the same address again
      do_txn(32'h9FC0_1234, 32'hDEAD_BEEF, 2'b00, 1, 1, 0, 1'b1, -1, 1'b0);
      s1 = obs_s;
      do_txn(32'h9FC0_1234, 32'hCAFE_F00D, 2'b00, 0, 0, 0, 1'b0, -1, 1'b0);
      chk("b2b_spacing", 32'(obs_s - s1), 32'd6);
      chk("b2b_araddr", obs_addr, 32'h1FC0_1234);

      // SLVERR beat still completes, and the error flag sticks
      do_txn(32'h0000_2000, 32'h1234_5678, 2'b10, 2, 0, 1, 1'b0, -1, 1'b0);
      chk("err_dout", obs_dout, 32'h1234_5678);
      chk("err_flag", 32'(obs_err), 32'd1);
      do_txn(32'h0000_2004, 32'h1111_1111, 2'b00, 0, 2, 0, 1'b0, -1, 1'b0);
      do_txn(32'h0000_2008, 32'h2222_2222, 2'b00, 1, 0, 2, 1'b0, -1, 1'b0);
      chk("err_sticky", 32'(obs_err), 32'd1);

      // reset during DATA, then a pending strobe restarts immediately
      do_txn(32'h0000_3000, 32'h3333_3333, 2'b00, 1, 6, 0, 1'b0, 4, 1'b0);
      do_txn(32'h9000_0040, 32'h4444_4444, 2'b00, 0, 0, 0, 1'b0, -1, 1'b1);
      chk("rst_restart_ar_at", 32'(obs_ar_first), 32'd1);
      chk("rst_restart_araddr", obs_addr, 32'h1000_0040);
      chk("rst_err_cleared", 32'(obs_err), 32'd0);

      pend_rst = 1'b0;
      for (int t = 0; t < 150; t++) begin
         ra = $urandom;
         if ($urandom % 2 == 1) ra[31:30] = 2'b10;
         rd = $urandom;
         rr = ($urandom % 6 == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
         rda = $urandom_range(0, 5);
         rdr = $urandom_range(0, 5);
         rab = ($urandom % 20 == 0) ? $urandom_range(1, 2 + rda + rdr) : -1;
         do_txn(ra, rd, rr, rda, rdr, $urandom_range(0, 3), 1'($urandom % 2), rab, pend_rst);
         pend_rst = (rab >= 0);
      end
      m_strobe = 1'b0;
      if (pend_rst) #1 rst = 1'b0;
      repeat (4) @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
      $finish;
   end

endmodule
